uart_line_receiver: RTL and testbench

Parametrised UART receive front end that deserialises 8-bit frames from `uartRx`, packs them LSB-first into `LineSize`-byte lines, and hands each line downstream over a valid/ready handshake. It replaces the fixed-format loader input path: it adds a configurable parity mode, framing/parity/overrun error reporting, a one-line output buffer with backpressure, and an idle-timeout flush that emits partial lines. It sits between the board GPIO receive pin and the memory-write sequencer.

---
 rtl/uart_line_receiver.sv | 166 ++++++++++++++++
 tb/tb_uart_line_receiver.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_line_receiver.sv
// UART receive front end: deserialises 8-bit frames, packs them LSB-first into
// LineSize-byte lines, and hands each line out through a one-entry valid/ready buffer.
module uart_line_receiver #(
    parameter int BaudRate        = 115200,
    parameter int ClockFrequency  = 50000000,
    parameter int LineSize        = 4,
    parameter int ParityMode      = 0,
    parameter int IdleTimeoutBits = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           uartRx,
    output logic                           lineValid,
    input  logic                           lineReady,
    output logic [LineSize*8-1:0]          lineValue,
    output logic [$clog2(LineSize+1)-1:0]  lineByteCount,
    output logic [31:0]                    totalByteCount,
    output logic                           frameError,
    output logic                           parityError,
    output logic                           overrun,
    input  logic                           clearErrors
);
    localparam int CPB = ClockFrequency / BaudRate;
    localparam int TW  = $clog2(CPB);
    localparam int CW  = $clog2(LineSize + 1);
    localparam logic [TW-1:0] HALF    = TW'(CPB / 2 - 1);
    localparam logic [TW-1:0] LAST    = TW'(CPB - 1);
    localparam logic [CW-1:0] FULL    = CW'(LineSize);
    localparam logic [31:0]   TO_LAST = 32'(IdleTimeoutBits * CPB - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

    logic                  rx_meta, rx_s;
    state_t                state;
    logic [TW-1:0]         bit_timer;
    logic [2:0]            bit_cnt;
    logic [7:0]            shreg;
    logic                  par_bad;
    logic [CW-1:0]         fill, next_fill;
    logic [LineSize*8-1:0] asm_line, next_line;
    logic [31:0]           idle_cnt;
    logic                  sample_pt, accept, timeout, complete, drain, load;
    logic                  set_fe, set_pe, set_ov;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uartRx;
            rx_s    <= rx_meta;
        end
    end

    assign sample_pt = (bit_timer == LAST);
    assign accept    = (state == STOP) && sample_pt && rx_s && !par_bad;
    assign set_fe    = (state == STOP) && sample_pt && !rx_s;
    assign set_pe    = (state == STOP) && sample_pt && rx_s && par_bad;
    assign timeout   = (IdleTimeoutBits != 0) && (state == IDLE) && (fill != '0)
                       && (idle_cnt == TO_LAST);
    assign next_fill = accept ? fill + CW'(1) : fill;
    assign complete  = (accept && next_fill == FULL) || timeout;
    assign drain     = lineValid && lineReady;
    assign load      = complete && (!lineValid || drain);
    assign set_ov    = complete && !load;

    always_comb begin
        next_line = asm_line;
        for (int k = 0; k < LineSize; k++)
            if (accept && fill == CW'(k)) next_line[8*k +: 8] = shreg;
    end

    // Receiver FSM: START is checked at half a bit, later bits every full bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bit_timer <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bad   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bit_timer <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (bit_timer == HALF) begin
                        bit_timer <= '0;
                        bit_cnt   <= '0;
                        par_bad   <= 1'b0;
                        state     <= rx_s ? IDLE : DATA;
                    end else bit_timer <= bit_timer + TW'(1);
                end
                DATA: begin
                    if (sample_pt) begin
                        bit_timer <= '0;
                        shreg     <= {rx_s, shreg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= (ParityMode != 0) ? PARITY : STOP;
                    end else bit_timer <= bit_timer + TW'(1);
                end
                PARITY: begin
                    if (sample_pt) begin
                        bit_timer <= '0;
                        par_bad   <= ((^shreg) ^ rx_s) != (ParityMode == 2);
                        state     <= STOP;
                    end else bit_timer <= bit_timer + TW'(1);
                end
                STOP: begin
                    if (sample_pt) begin
                        bit_timer <= '0;
                        state     <= rx_s ? IDLE : WAIT_HIGH;
                    end else bit_timer <= bit_timer + TW'(1);
                end
                WAIT_HIGH: if (rx_s) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    // Line assembly, output buffer, byte counter and sticky flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill           <= '0;
            asm_line       <= '0;
            idle_cnt       <= '0;
            lineValid      <= 1'b0;
            lineValue      <= '0;
            lineByteCount  <= '0;
            totalByteCount <= '0;
            frameError     <= 1'b0;
            parityError    <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            if (state == IDLE && fill != '0 && !timeout) idle_cnt <= idle_cnt + 32'd1;
            else                                         idle_cnt <= '0;

            if (complete) begin
                fill     <= '0;
                asm_line <= '0;
                if (load) begin
                    lineValid     <= 1'b1;
                    lineValue     <= next_line;
                    lineByteCount <= next_fill;
                    if (accept) totalByteCount <= totalByteCount + 32'd1;
                end else begin
                    // Dropped line: back out the bytes already counted for it.
                    totalByteCount <= totalByteCount - 32'(fill);
                    if (drain) lineValid <= 1'b0;
                end
            end else begin
                if (accept) begin
                    fill           <= next_fill;
                    asm_line       <= next_line;
                    totalByteCount <= totalByteCount + 32'd1;
                end
                if (drain) lineValid <= 1'b0;
            end

            frameError  <= set_fe | (frameError  & ~clearErrors);
            parityError <= set_pe | (parityError & ~clearErrors);
            overrun     <= set_ov | (overrun     & ~clearErrors);
        end
    end
endmodule

// File: tb/tb_uart_line_receiver.sv
// Self-checking bench: two receivers (no parity / even parity with idle flush)
// driven with serial frames and compared against a byte-queue line model.
module tb_uart_line_receiver;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tx = 1'b1;
    int          sel = 0;
    logic        rnd_ready = 1'b0;
    logic        lineReady = 1'b0;
    logic        clearErrors = 1'b0;
    logic        rx0, rx1;

    logic        lineValid0, lineValid1;
    logic [31:0] lineValue0, lineValue1;
    logic [2:0]  lineByteCount0, lineByteCount1;
    logic [31:0] totalByteCount0, totalByteCount1;
    logic        frameError0, parityError0, overrun0;
    logic        frameError1, parityError1, overrun1;

    int checks = 0;
    int passed = 0;

    logic [31:0] q0v[$], q1v[$];
    logic [2:0]  q0c[$], q1c[$];

    always #5 clk = ~clk;

    assign rx0 = (sel == 0) ? tx : 1'b1;
    assign rx1 = (sel == 1) ? tx : 1'b1;

    uart_line_receiver #(.BaudRate(1), .ClockFrequency(16), .LineSize(4),
                         .ParityMode(0), .IdleTimeoutBits(0)) dut0 (
        .clk(clk), .rst(rst), .uartRx(rx0), .lineValid(lineValid0), .lineReady(lineReady),
        .lineValue(lineValue0), .lineByteCount(lineByteCount0),
        .totalByteCount(totalByteCount0), .frameError(frameError0),
        .parityError(parityError0), .overrun(overrun0), .clearErrors(clearErrors));

    uart_line_receiver #(.BaudRate(1), .ClockFrequency(16), .LineSize(4),
                         .ParityMode(1), .IdleTimeoutBits(10)) dut1 (
        .clk(clk), .rst(rst), .uartRx(rx1), .lineValid(lineValid1), .lineReady(lineReady),
        .lineValue(lineValue1), .lineByteCount(lineByteCount1),
        .totalByteCount(totalByteCount1), .frameError(frameError1),
        .parityError(parityError1), .overrun(overrun1), .clearErrors(clearErrors));

    // Record every handshake as the consumer would see it.
    always @(posedge clk) begin
        if (rst) begin
            if (lineValid0 && lineReady) begin q0v.push_back(lineValue0); q0c.push_back(lineByteCount0); end
            if (lineValid1 && lineReady) begin q1v.push_back(lineValue1); q1c.push_back(lineByteCount1); end
        end
    end

    task automatic bit_time(input logic v);
        tx = v;
        repeat (16) begin
            @(negedge clk);
            if (rnd_ready) lineReady = 1'($urandom_range(0, 1));
        end
    endtask

    // par < 0: no parity bit; stop_low: extra bit times of a low stop bit.
    task automatic send(input logic [7:0] d, input int par, input int stop_low);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i]);
        if (par >= 0) bit_time(par[0]);
        for (int i = 0; i < stop_low; i++) bit_time(1'b0);
        bit_time(1'b1);
    endtask

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

    task automatic apply_reset();
        rst = 1'b0; tx = 1'b1; sel = 0; rnd_ready = 1'b0; lineReady = 1'b0; clearErrors = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        q0v.delete(); q0c.delete(); q1v.delete(); q1c.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0; tx = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({lineValid0, lineValue0, lineByteCount0, totalByteCount0, frameError0, parityError0, overrun0} !== '0)
            $display("FAIL reset_dut0: got v=%b val=%h cnt=%0d tot=%0d flags=%b%b%b want all zero",
                     lineValid0, lineValue0, lineByteCount0, totalByteCount0, frameError0, parityError0, overrun0);
        else passed++;
        checks++;
        if ({lineValid1, lineValue1, lineByteCount1, totalByteCount1, frameError1, parityError1, overrun1} !== '0)
            $display("FAIL reset_dut1: got v=%b val=%h cnt=%0d tot=%0d want all zero",
                     lineValid1, lineValue1, lineByteCount1, totalByteCount1);
        else passed++;
    endtask

    task automatic test_basic_line();
        apply_reset();
        lineReady = 1'b1;
        send(8'h11, -1, 0); send(8'h22, -1, 0); send(8'h33, -1, 0); send(8'h44, -1, 0);
        repeat (10) @(negedge clk);
        checks++;
        if (q0v.size() != 1 || q0v[0] !== 32'h44332211 || q0c[0] !== 3'd4)
            $display("FAIL basic_line: got n=%0d val=%h cnt=%0d want n=1 val=44332211 cnt=4",
                     q0v.size(), (q0v.size() > 0) ? q0v[0] : 32'h0, (q0c.size() > 0) ? q0c[0] : 3'd0);
        else passed++;
        checks++;
        if (totalByteCount0 !== 32'd4 || {frameError0, parityError0, overrun0} !== 3'b000 || lineValid0 !== 1'b0)
            $display("FAIL basic_status: got tot=%0d flags=%b%b%b v=%b want tot=4 flags=000 v=0",
                     totalByteCount0, frameError0, parityError0, overrun0, lineValid0);
        else passed++;
    endtask

    task automatic test_overrun();
        apply_reset();
        for (int i = 1; i <= 4; i++) send(8'(i), -1, 0);
        checks++;
        if (lineValid0 !== 1'b1 || lineValue0 !== 32'h04030201 || overrun0 !== 1'b0)
            $display("FAIL overrun_first: got v=%b val=%h ov=%b want v=1 val=04030201 ov=0",
                     lineValid0, lineValue0, overrun0);
        else passed++;
        for (int i = 5; i <= 8; i++) send(8'(i), -1, 0);
        checks++;
        if (lineValid0 !== 1'b1 || lineValue0 !== 32'h04030201 || lineByteCount0 !== 3'd4)
            $display("FAIL overrun_hold: got v=%b val=%h cnt=%0d want v=1 val=04030201 cnt=4",
                     lineValid0, lineValue0, lineByteCount0);
        else passed++;
        checks++;
        if (overrun0 !== 1'b1 || totalByteCount0 !== 32'd4)
            $display("FAIL overrun_flag: got ov=%b tot=%0d want ov=1 tot=4", overrun0, totalByteCount0);
        else passed++;
        clearErrors = 1'b1; @(negedge clk); clearErrors = 1'b0; @(negedge clk);
        checks++;
        if (overrun0 !== 1'b0)
            $display("FAIL overrun_clear: got ov=%b want 0", overrun0);
        else passed++;
        lineReady = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (lineValid0 !== 1'b0 || q0v.size() != 1 || q0v[0] !== 32'h04030201)
            $display("FAIL overrun_drain: got v=%b n=%0d want v=0 n=1", lineValid0, q0v.size());
        else passed++;
    endtask

    task automatic test_parity();
        apply_reset();
        sel = 1; lineReady = 1'b1;
        send(8'h03, 1, 0);
        checks++;
        if (parityError1 !== 1'b1 || totalByteCount1 !== 32'd0 || frameError1 !== 1'b0)
            $display("FAIL parity_bad: got pe=%b tot=%0d fe=%b want pe=1 tot=0 fe=0",
                     parityError1, totalByteCount1, frameError1);
        else passed++;
        send(8'h03, 0, 0);
        checks++;
        if (totalByteCount1 !== 32'd1)
            $display("FAIL parity_good: got tot=%0d want 1", totalByteCount1);
        else passed++;
        for (int i = 0; i < 300 && q1v.size() == 0; i++) @(negedge clk);
        checks++;
        if (q1v.size() != 1 || q1v[0] !== 32'h00000003 || q1c[0] !== 3'd1)
            $display("FAIL parity_flush: got n=%0d val=%h want n=1 val=00000003 cnt=1",
                     q1v.size(), (q1v.size() > 0) ? q1v[0] : 32'h0);
        else passed++;
    endtask

    task automatic test_frame_error();
        apply_reset();
        lineReady = 1'b1;
        send(8'h55, -1, 3);
        checks++;
        if (frameError0 !== 1'b1 || totalByteCount0 !== 32'd0)
            $display("FAIL frame_err: got fe=%b tot=%0d want fe=1 tot=0", frameError0, totalByteCount0);
        else passed++;
        send(8'hA5, -1, 0); send(8'h01, -1, 0); send(8'h02, -1, 0); send(8'h03, -1, 0);
        repeat (5) @(negedge clk);
        checks++;
        if (q0v.size() != 1 || q0v[0] !== 32'h030201A5 || totalByteCount0 !== 32'd4)
            $display("FAIL frame_recover: got n=%0d val=%h tot=%0d want n=1 val=030201a5 tot=4",
                     q0v.size(), (q0v.size() > 0) ? q0v[0] : 32'h0, totalByteCount0);
        else passed++;
    endtask

    task automatic test_timeout();
        apply_reset();
        sel = 1; lineReady = 1'b1;
        send(8'hAA, int'(even_par(8'hAA)), 0);
        send(8'hBB, int'(even_par(8'hBB)), 0);
        repeat (140) @(negedge clk);
        checks++;
        if (q1v.size() != 0 || lineValid1 !== 1'b0)
            $display("FAIL timeout_early: got n=%0d v=%b want n=0 v=0", q1v.size(), lineValid1);
        else passed++;
        for (int i = 0; i < 40 && q1v.size() == 0; i++) @(negedge clk);
        checks++;
        if (q1v.size() != 1 || q1v[0] !== 32'h0000BBAA || q1c[0] !== 3'd2)
            $display("FAIL timeout_flush: got n=%0d val=%h cnt=%0d want n=1 val=0000bbaa cnt=2",
                     q1v.size(), (q1v.size() > 0) ? q1v[0] : 32'h0, (q1c.size() > 0) ? q1c[0] : 3'd0);
        else passed++;
    endtask

    task automatic test_glitch();
        apply_reset();
        lineReady = 1'b1;
        tx = 1'b0; repeat (4) @(negedge clk); tx = 1'b1;
        repeat (200) @(negedge clk);
        checks++;
        if (totalByteCount0 !== 32'd0 || {frameError0, parityError0, overrun0} !== 3'b000 || q0v.size() != 0)
            $display("FAIL glitch: got tot=%0d flags=%b%b%b n=%0d want all zero",
                     totalByteCount0, frameError0, parityError0, overrun0, q0v.size());
        else passed++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i), -1, 0);
        send(8'h77, -1, 0);
        send(8'h55, -1, 3);
        bit_time(1'b0); bit_time(1'b1); bit_time(1'b0);
        rst = 1'b0;
        #1;
        checks++;
        if ({lineValid0, lineValue0, lineByteCount0, totalByteCount0, frameError0, parityError0, overrun0} !== '0)
            $display("FAIL reset_mid: got v=%b val=%h cnt=%0d tot=%0d fe=%b want all zero",
                     lineValid0, lineValue0, lineByteCount0, totalByteCount0, frameError0);
        else passed++;
        tx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        q0v.delete(); q0c.delete();
        lineReady = 1'b1;
        for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), -1, 0);
        repeat (5) @(negedge clk);
        checks++;
        if (q0v.size() != 1 || q0v[0] !== 32'h13121110 || totalByteCount0 !== 32'd4)
            $display("FAIL reset_partial: got n=%0d val=%h tot=%0d want n=1 val=13121110 tot=4",
                     q0v.size(), (q0v.size() > 0) ? q0v[0] : 32'h0, totalByteCount0);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] b[$];
        apply_reset();
        lineReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b.push_back(8'($urandom));
            send(b[i], -1, 0);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (q0v.size() != 2 || q0v[0] !== {b[3], b[2], b[1], b[0]} || q0v[1] !== {b[7], b[6], b[5], b[4]})
            $display("FAIL back_to_back: got n=%0d want n=2 lines %h %h",
                     q0v.size(), {b[3], b[2], b[1], b[0]}, {b[7], b[6], b[5], b[4]});
        else passed++;
    endtask

    // Random bytes with occasional bad parity; model is just the ordered list of
    // good bytes cut into 4-byte lines, with any remainder flushed by the timeout.
    task automatic test_random_parity();
        logic [7:0]  good[$];
        logic [31:0] exp_v[$];
        logic [2:0]  exp_c[$];
        logic [31:0] acc;
        int          any_bad;
        int          nerr;
        apply_reset();
        sel = 1; rnd_ready = 1'b1; any_bad = 0;
        for (int i = 0; i < 14; i++) begin
            logic [7:0] d;
            int bad;
            d = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0) ? 1 : 0;
            send(d, int'(even_par(d)) ^ bad, 0);
            for (int g = $urandom_range(0, 2); g > 0; g--) bit_time(1'b1);
            if (bad != 0) any_bad = 1; else good.push_back(d);
        end
        rnd_ready = 1'b0; lineReady = 1'b1;
        acc = '0;
        for (int i = 0; i < good.size(); i++) begin
            acc[8*(i%4) +: 8] = good[i];
            if (i % 4 == 3 || i == good.size() - 1) begin
                exp_v.push_back(acc); exp_c.push_back(3'(i % 4 + 1)); acc = '0;
            end
        end
        for (int i = 0; i < 400 && q1v.size() < exp_v.size(); i++) @(negedge clk);
        repeat (5) @(negedge clk);
        checks++;
        if (q1v.size() != exp_v.size())
            $display("FAIL rand_lines: got n=%0d want n=%0d", q1v.size(), exp_v.size());
        else passed++;
        nerr = 0;
        for (int i = 0; i < exp_v.size() && i < q1v.size(); i++)
            if (q1v[i] !== exp_v[i] || q1c[i] !== exp_c[i]) nerr++;
        checks++;
        if (nerr != 0)
            $display("FAIL rand_content: got %0d differing lines want 0", nerr);
        else passed++;
        checks++;
        if (totalByteCount1 !== 32'(good.size()) || parityError1 !== 1'(any_bad) || overrun1 !== 1'b0)
            $display("FAIL rand_status: got tot=%0d pe=%b ov=%b want tot=%0d pe=%0d ov=0",
                     totalByteCount1, parityError1, overrun1, good.size(), any_bad);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic_line();
        test_overrun();
        test_parity();
        test_frame_error();
        test_timeout();
        test_glitch();
        test_reset_mid();
        test_back_to_back();
        test_random_parity();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
